// File: rtl/fetch_ctrl_pkg.sv
// Shared types for the instruction-fetch request stage: exception codes and
// the in-flight queue entry layout.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ADEF = 2'd0,
    TLBR = 2'd1,
    PIF  = 2'd2,
    PPI  = 2'd3
  } excp_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        double;
    logic        data_pending;
    logic        excp;
    excp_t       excp_type;
    logic [63:0] inst;
  } fetch_entry_t;

  // Fault priority when several translation/alignment faults coincide.
  function automatic excp_t fault_type(input logic misaligned, input logic tlbr,
                                       input logic pif, input logic ppi);
    if (misaligned) return ADEF;
    if (tlbr)       return TLBR;
    if (pif)        return PIF;
    if (ppi)        return PPI;
    return ADEF;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// In-order circular buffer of fetch entries. Responses fill the oldest entry
// still waiting for data; the head is presented to decode.
module fetch_queue
  import fetch_ctrl_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            push,
  input  fetch_entry_t    push_entry,
  input  logic            pop,
  input  logic            fill,
  input  logic [63:0]     fill_data,
  output fetch_entry_t    head_entry,
  output logic [CW-1:0]   count,
  output logic [CW-1:0]   pending
);

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   head_ptr;
  logic [PW-1:0]   tail_ptr;
  logic [CW-1:0]   count_q;
  logic [PW-1:0]   fill_idx;
  logic            fill_hit;

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    fill_idx = head_ptr;
    fill_hit = 1'b0;
    pending  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_q && mem[PW'(head_ptr + PW'(i))].data_pending) begin
        pending = pending + CW'(1);
        if (!fill_hit) begin
          fill_idx = PW'(head_ptr + PW'(i));
          fill_hit = 1'b1;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count_q  <= '0;
    end else if (clear) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count_q  <= '0;
    end else begin
      if (push) tail_ptr <= PW'(tail_ptr + PW'(1));
      if (pop)  head_ptr <= PW'(head_ptr + PW'(1));
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: entry storage is not reset; pointers and count alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[tail_ptr] <= push_entry;
    if (fill && fill_hit && !clear) begin
      mem[fill_idx].data_pending <= 1'b0;
      mem[fill_idx].inst         <= fill_data;
    end
  end

  assign head_entry = mem[head_ptr];
  assign count      = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch request stage: owns the PC, issues single/double fetches,
// drops responses of flushed requests and hands entries to decode.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h1c00_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        i_req,
  output logic [31:0] i_va,
  input  logic        i_addr_ok,
  input  logic        i_double,
  input  logic        i_data_ok,
  input  logic [63:0] i_rdata,
  input  logic        i_tlbr,
  input  logic        i_pif,
  input  logic        i_ppi,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_double,
  output logic [31:0] out_pc,
  output logic [63:0] out_inst,
  output logic        out_excp,
  output excp_t       out_excp_type
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   pc;
  logic          stalled;
  logic [CW-1:0] discard_cnt;
  logic [CW-1:0] q_count;
  logic [CW-1:0] q_pending;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;
  logic          misaligned;
  logic          fault;
  logic          room;
  logic          can_issue;
  logic          push;
  logic          pop;
  logic          fill;
  logic          head_present;

  assign misaligned = pc[1:0] != 2'b00;
  assign fault      = misaligned | i_tlbr | i_pif | i_ppi;
  // Outstanding cache requests (queued + to-be-discarded) never exceed DEPTH.
  assign room       = ({1'b0, q_count} + {1'b0, discard_cnt}) < (CW + 1)'(DEPTH);
  assign can_issue  = !reset && !redirect_valid && !stalled && room;
  assign i_req      = can_issue && !fault;
  assign i_va       = pc;
  assign push       = can_issue && (fault || i_addr_ok);
  assign fill       = i_data_ok && (discard_cnt == '0) && !redirect_valid;

  always_comb begin
    push_entry    = '0;
    push_entry.pc = pc;
    if (fault) begin
      push_entry.excp      = 1'b1;
      push_entry.excp_type = fault_type(misaligned, i_tlbr, i_pif, i_ppi);
    end else begin
      push_entry.double       = i_double;
      push_entry.data_pending = 1'b1;
    end
  end

  assign head_present  = q_count != '0;
  assign out_valid     = head_present && !head.data_pending;
  assign pop           = out_valid && out_ready;
  assign out_pc        = head_present ? head.pc : '0;
  assign out_double    = head_present && head.double;
  assign out_inst      = head_present ? head.inst : '0;
  assign out_excp      = head_present && head.excp;
  assign out_excp_type = head_present ? head.excp_type : ADEF;

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk        (clk),
    .reset      (reset),
    .clear      (redirect_valid),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .fill       (fill),
    .fill_data  (i_rdata),
    .head_entry (head),
    .count      (q_count),
    .pending    (q_pending)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= RESET_PC;
      stalled     <= 1'b0;
      discard_cnt <= '0;
    end else if (redirect_valid) begin
      // A same-cycle response is charged to the oldest outstanding request.
      pc          <= redirect_pc;
      stalled     <= 1'b0;
      discard_cnt <= discard_cnt + q_pending - CW'(i_data_ok);
    end else begin
      if (i_data_ok && discard_cnt != '0) discard_cnt <= discard_cnt - CW'(1);
      if (can_issue && fault) stalled <= 1'b1;
      else if (i_req && i_addr_ok) pc <= pc + (i_double ? 32'd8 : 32'd4);
    end
  end

  a_no_orphan_resp : assert property (@(posedge clk) disable iff (reset)
    i_data_ok |-> (discard_cnt != '0 || q_pending != '0));

  a_outstanding_bound : assert property (@(posedge clk) disable iff (reset)
    ({1'b0, q_pending} + {1'b0, discard_cnt}) <= (CW + 1)'(DEPTH));

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: an MMU model answers accepted fetches
// one cycle later, and a scoreboard checks every entry handed to decode.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h1c00_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        i_req;
  logic [31:0] i_va;
  logic        i_addr_ok;
  logic        i_double;
  logic        i_data_ok;
  logic [63:0] i_rdata;
  logic        i_tlbr;
  logic        i_pif;
  logic        i_ppi;
  logic        out_valid;
  logic        out_ready;
  logic        out_double;
  logic [31:0] out_pc;
  logic [63:0] out_inst;
  logic        out_excp;
  excp_t       out_excp_type;

  typedef struct {
    logic [31:0] pc;
    logic        dbl;
    logic        excp;
    excp_t       etype;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mmu_q[$];
  exp_t        e;
  logic [31:0] model_pc;
  logic        model_stalled;
  logic        dbl_en, aok_en, resp_en, tlbr_en;
  logic [31:0] resp_va;
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          seen_line_end = 1'b0;

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .i_req          (i_req),
    .i_va           (i_va),
    .i_addr_ok      (i_addr_ok),
    .i_double       (i_double),
    .i_data_ok      (i_data_ok),
    .i_rdata        (i_rdata),
    .i_tlbr         (i_tlbr),
    .i_pif          (i_pif),
    .i_ppi          (i_ppi),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_double     (out_double),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .out_excp       (out_excp),
    .out_excp_type  (out_excp_type)
  );

  // Cache model: double fetch unless the second word would cross a 64-byte line.
  function automatic logic dbl_of(input logic [31:0] a);
    return dbl_en && (a[5:2] != 4'hf);
  endfunction

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h5a5a_c3c3;
  endfunction

  assign i_double  = dbl_of(i_va);
  assign i_addr_ok = aok_en;
  assign i_tlbr    = tlbr_en;
  assign i_pif     = 1'b0;
  assign i_ppi     = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // MMU response side: one in-order response per cycle after acceptance.
  always @(posedge clk) begin
    #1;
    if (!reset && resp_en && mmu_q.size() > 0) begin
      resp_va   = mmu_q.pop_front();
      i_data_ok = 1'b1;
      i_rdata   = {inst_of(resp_va + 32'd4), inst_of(resp_va)};
    end else begin
      i_data_ok = 1'b0;
      i_rdata   = '0;
    end
  end

  // Monitor and scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", out_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          if (out_pc == 32'h1c00_003c) seen_line_end = 1'b1;
          check("out_pc", out_pc, e.pc);
          check("out_excp", out_excp, e.excp);
          if (e.excp) begin
            check("out_excp_type", out_excp_type, e.etype);
            check("excp_double", out_double, 1'b0);
            check("excp_inst", out_inst, 64'h0);
          end else begin
            check("out_double", out_double, e.dbl);
            check("inst_lo", out_inst[31:0], inst_of(e.pc));
            if (e.dbl) check("inst_hi", out_inst[63:32], inst_of(e.pc + 32'd4));
          end
        end
      end
      if (redirect_valid) begin
        check("req_during_redirect", i_req, 1'b0);
        exp_q.delete();
        model_pc      = redirect_pc;
        model_stalled = redirect_pc[1:0] != 2'b00;
        if (model_stalled) exp_q.push_back('{redirect_pc, 1'b0, 1'b1, ADEF});
      end else if (i_req && i_addr_ok) begin
        check("i_va", i_va, model_pc);
        check("issue_while_stalled", model_stalled, 1'b0);
        exp_q.push_back('{model_pc, dbl_of(model_pc), 1'b0, ADEF});
        mmu_q.push_back(i_va);
        model_pc = model_pc + (dbl_of(model_pc) ? 32'd8 : 32'd4);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
  endtask

  task automatic wait_outstanding(input int n);
    for (int i = 0; i < 200; i++) begin
      if (mmu_q.size() >= n) break;
      @(posedge clk); #1;
    end
    check("outstanding_reached", mmu_q.size() >= n, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    i_data_ok      = 1'b0;
    i_rdata        = '0;
    out_ready      = 1'b1;
    dbl_en         = 1'b1;
    aok_en         = 1'b1;
    resp_en        = 1'b1;
    tlbr_en        = 1'b0;
    model_pc       = RESET_PC;
    model_stalled  = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_i_req", i_req, 1'b0);
    check("reset_out_excp", out_excp, 1'b0);
    check("reset_out_pc", out_pc, 32'h0);
    reset = 1'b0;

    // Streaming double fetches from the reset PC.
    cycles(20);

    // Line end: 1c000034 double, 1c00003c single, then 1c000040.
    do_redirect(32'h1c00_0034);
    cycles(12);

    // Redirect with two requests outstanding and no response yet.
    @(negedge clk); resp_en = 1'b0;
    wait_outstanding(2);
    @(negedge clk);
    check("full_blocks_issue", i_req, 1'b0);
    do_redirect(32'h1c00_1000);
    @(negedge clk);
    check("discard_blocks_issue", i_req, 1'b0);
    check("discard_no_valid", out_valid, 1'b0);
    resp_en = 1'b1;
    cycles(15);

    // Redirect in the same cycle as a response with two pending.
    @(negedge clk); resp_en = 1'b0;
    wait_outstanding(2);
    @(negedge clk); resp_en = 1'b1;
    do_redirect(32'h1c00_2000);
    @(negedge clk);
    check("no_stale_valid_0", out_valid, 1'b0);
    @(negedge clk);
    check("no_stale_valid_1", out_valid, 1'b0);
    cycles(10);

    // Misaligned target: ADEF entry, then fetch stays stalled.
    do_redirect(32'h1c00_0002);
    cycles(10);
    @(negedge clk);
    check("adef_stall_no_req", i_req, 1'b0);
    check("adef_delivered", exp_q.size(), 0);

    // Backpressure fills the queue, then drains in order; then a TLB refill fault.
    do_redirect(32'h1c00_0200);
    cycles(3);
    out_ready = 1'b0;
    cycles(10);
    @(negedge clk);
    check("full_out_valid", out_valid, 1'b1);
    check("full_no_req", i_req, 1'b0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    cycles(6);
    tlbr_en       = 1'b1;
    model_stalled = 1'b1;
    exp_q.push_back('{model_pc, 1'b0, 1'b1, TLBR});
    cycles(10);
    @(negedge clk);
    check("tlbr_stall_no_req", i_req, 1'b0);
    check("tlbr_delivered", exp_q.size(), 0);

    // Resume, then stop accepting and let everything drain.
    tlbr_en = 1'b0;
    do_redirect(32'h1c00_0300);
    cycles(8);
    aok_en = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0 && mmu_q.size() == 0) break;
      @(posedge clk); #1;
    end
    check("drain_expected", exp_q.size(), 0);
    check("drain_mmu", mmu_q.size(), 0);
    check("line_end_seen", seen_line_end, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
